// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among N_REQ requesters with round-robin arbitration.
// Build option ALU_ARB_FIXED_PRIO_EN: lowest-index requester always wins, no rotation pointer.
module alu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int NB_OP   = 6,
  parameter int NB_AB   = 8,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*NB_OP-1:0] req_op,
  input  logic [N_REQ*NB_AB-1:0] req_a,
  input  logic [N_REQ*NB_AB-1:0] req_b,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [NB_AB-1:0]       result_out,
  output logic                   busy,
  output logic [NB_OP-1:0]       op_code,
  output logic [NB_AB-1:0]       data_a,
  output logic [NB_AB-1:0]       data_b,
  input  logic [NB_AB-1:0]       alu_result
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] win_q;
  logic [IDX_W-1:0] win_d;
  logic             win_vld_d;

  logic [NB_OP-1:0] op_arr [N_REQ];
  logic [NB_AB-1:0] a_arr  [N_REQ];
  logic [NB_AB-1:0] b_arr  [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[gi*NB_OP +: NB_OP];
      assign a_arr[gi]  = req_a[gi*NB_AB +: NB_AB];
      assign b_arr[gi]  = req_b[gi*NB_AB +: NB_AB];
    end
  endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    win_vld_d = |req;
    win_d     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[IDX_W'(k)]) begin
        win_d = IDX_W'(k);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q;

  // First set request at or above rr_ptr_q, wrapping past the top index.
  always_comb begin
    int cand;
    cand      = 0;
    win_vld_d = 1'b0;
    win_d     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!win_vld_d && req[IDX_W'(cand)]) begin
        win_vld_d = 1'b1;
        win_d     = IDX_W'(cand);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      win_q      <= '0;
      gnt        <= '0;
      done       <= '0;
      result_out <= '0;
      busy       <= 1'b0;
      op_code    <= '0;
      data_a     <= '0;
      data_b     <= '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
      rr_ptr_q   <= '0;
`endif
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            op_code <= op_arr[win_d];
            data_a  <= a_arr[win_d];
            data_b  <= b_arr[win_d];
            gnt     <= ONE_HOT0 << win_d;
            win_q   <= win_d;
            cnt_q   <= CNT_W'(ALU_LAT - 1);
            busy    <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          // Operands stay on the ALU bus until the next grant.
          if (cnt_q == '0) begin
            result_out <= alu_result;
            done       <= ONE_HOT0 << win_q;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
`ifdef ALU_ARB_FIXED_PRIO_EN
`else
          rr_ptr_q <= (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
`endif
        end
        default: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level schedule model.
module tb_alu_arbiter;

  localparam int N    = 4;
  localparam int OPW  = 6;
  localparam int W    = 8;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [N-1:0]     req;
  logic [N*OPW-1:0] req_op;
  logic [N*W-1:0]   req_a, req_b;
  logic [N-1:0]     gnt, done;
  logic [W-1:0]     result_out, data_a, data_b, alu_result;
  logic             busy;
  logic [OPW-1:0]   op_code;

  logic [OPW-1:0] op_v [N];
  logic [W-1:0]   a_v  [N];
  logic [W-1:0]   b_v  [N];

  logic [N-1:0]     req3;
  logic [N*OPW-1:0] req_op3;
  logic [N*W-1:0]   req_a3, req_b3;
  logic [N-1:0]     gnt3, done3;
  logic [W-1:0]     result3, data_a3, data_b3, alu_result3;
  logic             busy3;
  logic [OPW-1:0]   op_code3;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int             edge_k = 0;
  int             free_edge, g_edge, done_edge, ptr;
  logic [N-1:0]   exp_gnt, exp_done, pend_mask;
  logic [W-1:0]   exp_res, pend_res, exp_a, exp_b;
  logic [OPW-1:0] exp_op;
  logic           exp_busy;

  function automatic logic [W-1:0] alu_f(input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  assign alu_result  = alu_f(op_code, data_a, data_b);
  assign alu_result3 = alu_f(op_code3, data_a3, data_b3);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_op[gi*OPW +: OPW] = op_v[gi];
      assign req_a[gi*W +: W]      = a_v[gi];
      assign req_b[gi*W +: W]      = b_v[gi];
    end
  endgenerate

  alu_arbiter #(.N_REQ(N), .NB_OP(OPW), .NB_AB(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result_out(result_out), .busy(busy),
    .op_code(op_code), .data_a(data_a), .data_b(data_b), .alu_result(alu_result)
  );

  alu_arbiter #(.N_REQ(N), .NB_OP(OPW), .NB_AB(W), .ALU_LAT(LAT3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_op(req_op3), .req_a(req_a3), .req_b(req_b3),
    .gnt(gnt3), .done(done3), .result_out(result3), .busy(busy3),
    .op_code(op_code3), .data_a(data_a3), .data_b(data_b3), .alu_result(alu_result3)
  );

  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [1:0] ii;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) begin
      ii = 2'(k);
      if (r[ii]) return k;
    end
`else
    for (int k = 0; k < N; k++) begin
      ii = 2'((p + k) % N);
      if (r[ii]) return (p + k) % N;
    end
`endif
    return 0;
  endfunction

  task automatic model_reset();
    ptr = 0; free_edge = 0; g_edge = -100; done_edge = -1;
    exp_gnt = '0; exp_done = '0; exp_res = '0; exp_op = '0;
    exp_a = '0; exp_b = '0; exp_busy = 1'b0; pend_mask = '0; pend_res = '0;
  endtask

  // A grant at edge g books the ALU until edge g+LAT+2 and schedules done at g+LAT.
  task automatic model_edge();
    int w;
    logic [1:0] wi;
    edge_k++;
    exp_gnt  = '0;
    exp_done = '0;
    if (edge_k == done_edge) begin
      exp_done = pend_mask;
      exp_res  = pend_res;
    end
    exp_busy = (edge_k >= g_edge) && (edge_k <= g_edge + LAT);
    if (edge_k >= free_edge && req != '0) begin
      w  = pick(req, ptr);
      wi = 2'(w);
      exp_gnt   = 4'b0001 << wi;
      exp_op    = op_v[wi];
      exp_a     = a_v[wi];
      exp_b     = b_v[wi];
      pend_mask = 4'b0001 << wi;
      pend_res  = alu_f(op_v[wi], a_v[wi], b_v[wi]);
      g_edge    = edge_k;
      done_edge = edge_k + LAT;
      free_edge = edge_k + LAT + 2;
      ptr       = (w + 1) % N;
      exp_busy  = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    if (done != '0) $display("txn: done=%b result=%h t=%0t", done, result_out, $time);
  endtask

  task automatic clear_inputs();
    req = '0;
    for (int i = 0; i < N; i++) begin
      op_v[2'(i)] = '0; a_v[2'(i)] = '0; b_v[2'(i)] = '0;
    end
    req3 = '0; req_op3 = '0; req_a3 = '0; req_b3 = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, done, result_out, busy, op_code, data_a, data_b} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", {gnt, done, result_out, busy, op_code, data_a, data_b});
    end
    checks++;
    if ({gnt3, done3, result3, busy3, op_code3, data_a3, data_b3} !== '0) begin
      errors++; $display("FAIL reset_outputs_lat3: got %h expected 0", {gnt3, done3, result3, busy3, op_code3, data_a3, data_b3});
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    op_v[0] = 6'h20; a_v[0] = 8'h05; b_v[0] = 8'h03; req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    checks++;
    if ({op_code, data_a, data_b} !== {6'h20, 8'h05, 8'h03}) begin
      errors++; $display("FAIL single_operands: got %h/%h/%h expected 20/05/03", op_code, data_a, data_b);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    req = '0;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_drop: got %b expected 0000", gnt); end
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b expected 0001", done); end
    checks++; if (result_out !== 8'h08) begin errors++; $display("FAIL single_result: got %h expected 08", result_out); end
    tick();
    checks++; if (done !== 4'b0000) begin errors++; $display("FAIL single_done_drop: got %b expected 0000", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_ord [5];
    logic [N-1:0] last_g;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 2, 3, 0};
`endif
    last_g = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      op_v[2'(i)] = 6'h20; a_v[2'(i)] = 8'(i * 16); b_v[2'(i)] = 8'(i + 1);
    end
    req = 4'b1111;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (gnt !== '0) begin
        checks++; if (!$onehot(gnt)) begin errors++; $display("FAIL rr_onehot: got %b expected one-hot", gnt); end
        for (int i = 0; i < N; i++) if (gnt[2'(i)]) order.push_back(i);
        last_g = gnt;
      end
      if (done !== '0) begin
        checks++; if (done !== last_g) begin errors++; $display("FAIL rr_done: got %b expected %b", done, last_g); end
      end
    end
    req = '0;
    checks++;
    if (order.size() != 5) begin
      errors++; $display("FAIL rr_count: got %0d grants expected 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (order[k] != exp_ord[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], exp_ord[k]); end
      end
    end
  endtask

  task automatic test_latency();
    logic [N-1:0] exp_d;
    req_op3 = {6'h00, 6'h22, 6'h00, 6'h00};
    req_a3  = {8'h00, 8'h10, 8'h00, 8'h00};
    req_b3  = {8'h00, 8'h01, 8'h00, 8'h00};
    req3    = 4'b0100;
    tick();
    checks++; if (gnt3 !== 4'b0100) begin errors++; $display("FAIL lat_gnt: got %b expected 0100", gnt3); end
    req3   = '0;
    req_a3 = {8'h00, 8'hEE, 8'h00, 8'h00};
    for (int i = 1; i <= LAT3; i++) begin
      tick();
      exp_d = (i == LAT3) ? 4'b0100 : 4'b0000;
      checks++; if (data_a3 !== 8'h10) begin errors++; $display("FAIL lat_hold[%0d]: got %h expected 10", i, data_a3); end
      checks++; if (done3 !== exp_d) begin errors++; $display("FAIL lat_done[%0d]: got %b expected %b", i, done3, exp_d); end
    end
    checks++; if (result3 !== 8'h0F) begin errors++; $display("FAIL lat_result: got %h expected 0F", result3); end
    tick();
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL lat_idle: got busy %b expected 0", busy3); end
  endtask

  task automatic test_operand_change();
    op_v[1] = 6'h20; a_v[1] = 8'h07; b_v[1] = 8'h02; req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL opchg_gnt: got %b expected 0010", gnt); end
    a_v[1] = 8'hFF; req = '0;
    tick();
    checks++; if (data_a !== 8'h07) begin errors++; $display("FAIL opchg_data_a: got %h expected 07", data_a); end
    checks++; if (done !== 4'b0010) begin errors++; $display("FAIL opchg_done: got %b expected 0010", done); end
    checks++; if (result_out !== 8'h09) begin errors++; $display("FAIL opchg_result: got %h expected 09", result_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    op_v[3] = 6'h20; a_v[3] = 8'h30; b_v[3] = 8'h01; req = 4'b1000;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rstmid_gnt: got %b expected 1000", gnt); end
    req = '0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, done, result_out, busy, op_code, data_a, data_b} !== '0) begin
      errors++; $display("FAIL rstmid_async: got %h expected 0", {gnt, done, result_out, busy, op_code, data_a, data_b});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, result_out} !== '0) begin errors++; $display("FAIL rstmid_no_done: got done %b result %h expected 0", done, result_out); end
    @(negedge clk);
    reset = 1'b1;
    op_v[1] = 6'h20; a_v[1] = 8'h11; b_v[1] = 8'h22;
    op_v[2] = 6'h20; a_v[2] = 8'h01; b_v[2] = 8'h01;
    req = 4'b0110;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_ptr: got %b expected 0010", gnt); end
    req = '0;
    tick();
    checks++; if (result_out !== 8'h33) begin errors++; $display("FAIL rstmid_result: got %h expected 33", result_out); end
    tick();
  endtask

  task automatic test_late_request();
    op_v[0] = 6'h20; a_v[0] = 8'h01; b_v[0] = 8'h02;
    op_v[3] = 6'h22; a_v[3] = 8'h09; b_v[3] = 8'h04;
    req = 4'b0001;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL late_gnt0: got %b expected 0001", gnt); end
    req = 4'b1000;
    tick();
    checks++; if (done !== 4'b0001) begin errors++; $display("FAIL late_done0: got %b expected 0001", done); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL late_wait_gnt: got %b expected 0000", gnt); end
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL late_done_gnt: got %b expected 0000", gnt); end
    checks++; if (result_out !== 8'h03) begin errors++; $display("FAIL late_hold: got %h expected 03", result_out); end
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL late_gnt3: got %b expected 1000", gnt); end
    checks++; if (result_out !== 8'h03) begin errors++; $display("FAIL late_hold2: got %h expected 03", result_out); end
    req = '0;
    tick();
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL late_done3: got %b expected 1000", done); end
    checks++; if (result_out !== 8'h05) begin errors++; $display("FAIL late_result3: got %h expected 05", result_out); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req[2'(i)] = ~req[2'(i)];
        if ($urandom_range(0, 1) == 0) begin
          op_v[2'(i)] = 6'(32'h20 + $urandom_range(0, 6));
          a_v[2'(i)]  = 8'($urandom);
          b_v[2'(i)]  = 8'($urandom);
        end
      end
      tick();
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d: got %b expected %b", c, gnt, exp_gnt); end
      checks++; if (done !== exp_done) begin errors++; $display("FAIL rnd_done c=%0d: got %b expected %b", c, done, exp_done); end
      checks++; if (result_out !== exp_res) begin errors++; $display("FAIL rnd_result c=%0d: got %h expected %h", c, result_out, exp_res); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, exp_busy); end
      checks++;
      if ({op_code, data_a, data_b} !== {exp_op, exp_a, exp_b}) begin
        errors++; $display("FAIL rnd_operands c=%0d: got %h/%h/%h expected %h/%h/%h", c, op_code, data_a, data_b, exp_op, exp_a, exp_b);
      end
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_latency();
    test_operand_change();
    test_reset_mid();
    test_late_request();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
